// File: rtl/pixel_framebuffer.sv
// Double-buffered X/Y pixel store: scan-out reads the front bank with 2-cycle latency,
// drawing writes and the clear engine target the back bank, and swaps wait for frame_end.
module pixel_framebuffer #(
  parameter int h_size      = 640,
  parameter int v_line      = 480,
  parameter int color_depth = 8,
  parameter logic [color_depth-1:0] bg_color = {color_depth{1'b0}},
  // Coordinate widths can also express h_size / v_line, so out-of-range requests are possible.
  parameter int hw = $clog2(h_size + 1),
  parameter int vw = $clog2(v_line + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [hw-1:0]          h_pixel_read,
  input  logic [vw-1:0]          v_pixel_read,
  output logic [color_depth-1:0] color_read,
  input  logic                   write_valid,
  output logic                   write_ready,
  input  logic [hw-1:0]          h_pixel_write,
  input  logic [vw-1:0]          v_pixel_write,
  input  logic [color_depth-1:0] color_write,
  input  logic                   clear_start,
  input  logic [color_depth-1:0] clear_color,
  input  logic                   swap_req,
  input  logic                   frame_end,
  output logic                   busy,
  output logic                   front_sel
);

  localparam int ram_size = h_size * v_line;
  localparam int aw       = $clog2(ram_size);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  function automatic logic [aw-1:0] to_addr(input logic [hw-1:0] h, input logic [vw-1:0] v);
    return aw'(int'(v) * h_size + int'(h));
  endfunction

  function automatic logic in_range(input logic [hw-1:0] h, input logic [vw-1:0] v);
    return (int'(h) < h_size) && (int'(v) < v_line);
  endfunction

  logic [color_depth-1:0] mem_r [0:1][0:ram_size-1];

  state_t                 state_r, state_s;
  logic [aw-1:0]          cnt_r;
  logic [color_depth-1:0] clr_color_r;
  logic                   front_sel_r;
  logic                   busy_r, ready_r;
  logic                   last_s, accept_s;

  logic [aw-1:0]          rd_addr_r;
  logic                   rd_ok_r, rd_sel_r;
  logic [color_depth-1:0] color_r;

  logic                   wr_pend_r;
  logic [aw-1:0]          wr_addr_r;
  logic [color_depth-1:0] wr_data_r;

  assign last_s   = (cnt_r == aw'(ram_size - 1));
  assign accept_s = write_valid && ready_r;

  // Next-state logic; clear_start outranks swap_req, both ignored outside IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (clear_start) begin
          state_s = CLEAR;
        end else if (swap_req) begin
          state_s = SWAP_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        if (last_s) begin
          state_s = IDLE;
        end else begin
          state_s = CLEAR;
        end
      end
      SWAP_WAIT: begin
        if (frame_end) begin
          state_s = IDLE;
        end else begin
          state_s = SWAP_WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, clear counter, bank select and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= {aw{1'b0}};
      clr_color_r <= {color_depth{1'b0}};
      front_sel_r <= 1'b0;
      busy_r      <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      ready_r <= (state_s == IDLE);
      if (state_r == IDLE && clear_start) begin
        cnt_r       <= {aw{1'b0}};
        clr_color_r <= clear_color;
      end else if (state_r == CLEAR) begin
        cnt_r <= last_s ? {aw{1'b0}} : cnt_r + {{(aw-1){1'b0}}, 1'b1};
      end
      if (state_r == SWAP_WAIT && frame_end) begin
        front_sel_r <= ~front_sel_r;
      end
    end
  end

  // Accepted pixel is held one cycle before landing; out-of-range pixels are dropped here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_pend_r <= 1'b0;
      wr_addr_r <= {aw{1'b0}};
      wr_data_r <= {color_depth{1'b0}};
    end else begin
      wr_pend_r <= accept_s && in_range(h_pixel_write, v_pixel_write);
      wr_addr_r <= to_addr(h_pixel_write, v_pixel_write);
      wr_data_r <= color_write;
    end
  end

  // Back-bank write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (state_r == CLEAR) begin
      mem_r[~front_sel_r][cnt_r] <= clr_color_r;
    end else if (wr_pend_r) begin
      mem_r[~front_sel_r][wr_addr_r] <= wr_data_r;
    end
  end

  // Read pipeline: bank choice is frozen at stage 1 so in-flight reads survive a swap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_r <= {aw{1'b0}};
      rd_ok_r   <= 1'b0;
      rd_sel_r  <= 1'b0;
      color_r   <= bg_color;
    end else begin
      rd_addr_r <= to_addr(h_pixel_read, v_pixel_read);
      rd_ok_r   <= in_range(h_pixel_read, v_pixel_read);
      rd_sel_r  <= front_sel_r;
      color_r   <= rd_ok_r ? mem_r[rd_sel_r][rd_addr_r] : bg_color;
    end
  end

  assign color_read  = color_r;
  assign write_ready = ready_r;
  assign busy        = busy_r;
  assign front_sel   = front_sel_r;

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Scoreboard bench for pixel_framebuffer on an 8x4 frame: reads push expected pixels
// from a two-bank reference model and a negedge monitor compares them on arrival.
module tb_pixel_framebuffer;

  localparam int HS = 8;
  localparam int VL = 4;
  localparam int CD = 8;
  localparam int HW = $clog2(HS + 1);
  localparam int VW = $clog2(VL + 1);
  localparam int RS = HS * VL;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [HW-1:0] h_pixel_read = '0;
  logic [VW-1:0] v_pixel_read = '0;
  logic [CD-1:0] color_read;
  logic          write_valid = 1'b0;
  logic          write_ready;
  logic [HW-1:0] h_pixel_write = '0;
  logic [VW-1:0] v_pixel_write = '0;
  logic [CD-1:0] color_write = '0;
  logic          clear_start = 1'b0;
  logic [CD-1:0] clear_color = '0;
  logic          swap_req = 1'b0;
  logic          frame_end = 1'b0;
  logic          busy;
  logic          front_sel;

  pixel_framebuffer #(.h_size(HS), .v_line(VL), .color_depth(CD), .bg_color(8'h00)) dut (
    .clk(clk), .reset(reset),
    .h_pixel_read(h_pixel_read), .v_pixel_read(v_pixel_read), .color_read(color_read),
    .write_valid(write_valid), .write_ready(write_ready),
    .h_pixel_write(h_pixel_write), .v_pixel_write(v_pixel_write), .color_write(color_write),
    .clear_start(clear_start), .clear_color(clear_color),
    .swap_req(swap_req), .frame_end(frame_end),
    .busy(busy), .front_sel(front_sel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [CD-1:0] model [0:1][0:RS-1];
  logic          front_m = 1'b0;
  logic [CD-1:0] exp_q[$];
  int            due_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] == cyc) begin
      check("color_read", 32'(color_read), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
  end

  task automatic rd(input int h, input int v);
    h_pixel_read = HW'(h);
    v_pixel_read = VW'(v);
    if (h < HS && v < VL) exp_q.push_back(model[front_m][v*HS + h]);
    else exp_q.push_back(8'h00);
    due_q.push_back(cyc + 2);
    @(posedge clk); #1;
  endtask

  task automatic rd_all();
    for (int v = 0; v < VL; v++)
      for (int h = 0; h < HS; h++) rd(h, v);
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && due_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    check("sb_drain", 32'(due_q.size()), 32'd0);
  endtask

  task automatic wr(input int h, input int v, input logic [CD-1:0] c);
    write_valid = 1'b1;
    h_pixel_write = HW'(h);
    v_pixel_write = VW'(v);
    color_write = c;
    check("wr_ready", 32'(write_ready), 32'd1);
    if (h < HS && v < VL) model[~front_m][v*HS + h] = c;
    @(posedge clk); #1;
    write_valid = 1'b0;
  endtask

  task automatic swap();
    swap_req = 1'b1;
    @(posedge clk); #1;
    swap_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("swap_wait_busy", 32'(busy), 32'd1);
    check("swap_wait_front", 32'(front_sel), 32'(front_m));
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    front_m = ~front_m;
    check("swap_front", 32'(front_sel), 32'(front_m));
    check("swap_busy", 32'(busy), 32'd0);
  endtask

  task automatic start_clear(input logic [CD-1:0] c, input logic with_swap);
    clear_start = 1'b1;
    clear_color = c;
    swap_req = with_swap;
    @(posedge clk); #1;
    clear_start = 1'b0;
    swap_req = 1'b0;
  endtask

  initial begin
    int nb, nr;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < RS; a++) model[b][a] = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_front", 32'(front_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(write_ready), 32'd1);
    check("rst_color", 32'(color_read), 32'd0);
    rd(3, 2);
    drain();

    // Back-bank write is invisible until swapped; coincident swap_req+frame_end must not swap
    wr(3, 2, 8'hA5);
    rd(3, 2);
    drain();
    swap_req = 1'b1;
    frame_end = 1'b1;
    @(posedge clk); #1;
    swap_req = 1'b0;
    frame_end = 1'b0;
    check("coinc_busy", 32'(busy), 32'd1);
    check("coinc_front", 32'(front_sel), 32'd0);
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    front_m = 1'b1;
    check("swap1_front", 32'(front_sel), 32'd1);
    check("swap1_busy", 32'(busy), 32'd0);
    rd(3, 2);
    drain();

    // Clear engine occupies exactly RS cycles
    start_clear(8'h3C, 1'b0);
    nb = 0;
    nr = 0;
    for (int i = 0; i < RS + 8; i++) begin
      if (busy) nb++;
      if (!write_ready) nr++;
      @(posedge clk); #1;
    end
    for (int a = 0; a < RS; a++) model[~front_m][a] = 8'h3C;
    check("clr_busy_len", 32'(nb), 32'(RS));
    check("clr_ready_len", 32'(nr), 32'(RS));
    swap();
    rd_all();
    drain();

    // Out-of-range reads return background; out-of-range writes are dropped
    rd(8, 0);
    rd(0, 4);
    rd(HS + 7, VL + 3);
    rd(7, 3);
    drain();
    wr(8, 1, 8'h77);
    wr(2, 4, 8'h66);
    swap();
    rd_all();
    drain();

    // clear_start beats swap_req; no swap on the next frame_end
    start_clear(8'h5A, 1'b1);
    for (int i = 0; i < RS + 8 && busy; i++) begin
      @(posedge clk); #1;
    end
    check("clr2_done", 32'(busy), 32'd0);
    for (int a = 0; a < RS; a++) model[~front_m][a] = 8'h5A;
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    check("clr_swap_drop", 32'(front_sel), 32'(front_m));
    check("clr_swap_busy", 32'(busy), 32'd0);

    // Reset after 10 clear cycles: partial fill kept, bank 0 becomes front again
    start_clear(8'hC3, 1'b0);
    for (int a = 0; a < 10; a++) model[~front_m][a] = 8'hC3;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_front", 32'(front_sel), 32'd0);
    check("abort_color", 32'(color_read), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    front_m = 1'b0;
    @(posedge clk); #1;
    rd_all();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
